multiplier_4bit: RTL and testbench
==================================

Name: multiplier_4bit

Overview:
- Sequential shift-and-add unsigned multiplier. It is the multiply counterpart to the team's restoring divider and shares the same clock-gated, enable-driven sequencing style.
- Takes two C_NUM_BITS operands and produces a 2*C_NUM_BITS product after C_NUM_BITS iteration cycles.
- Reports the result through a held product register and a one-cycle DONE pulse.
- Sits beside the divider in the arithmetic datapath. The product feeds downstream logic that samples on DONE.

Parameters:
- C_NUM_BITS, 4, operand width; product width is 2*C_NUM_BITS. The bench must cover C_NUM_BITS = 4.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RN  input  1  reset; asynchronous, active-low.
- E  input  1  clock enable; when low, all internal state and outputs hold (clock gated).
- START  input  1  begin a multiply; sampled only in IDLE with E high.
- A  input  C_NUM_BITS  multiplicand; captured on an accepted START.
- B  input  C_NUM_BITS  multiplier; captured on an accepted START.
- P  output  2*C_NUM_BITS  product; registered, holds last completed result.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse in DONE state; P is valid when DONE is high.

Behaviour:
- Reset (RN low, asynchronous):
  - state=IDLE; P=0, BUSY=0, DONE=0.
  - Internal multiplicand M=0, accumulator ACC=0 (C_NUM_BITS+1 bits incl. carry), multiplier shift register Q=0, iteration counter CNT=0.
- Reset release: first active edge with RN high and E high starts normal operation.
- States and transitions (all transitions require E high at the edge):
  - IDLE:
    - START=1: M<=A, Q<=B, ACC<=0, CNT<=0, go RUN.
    - Otherwise stay in IDLE.
  - RUN, one iteration per edge:
    - If Q[0]=1, sum = ACC[C_NUM_BITS-1:0] + M as (C_NUM_BITS+1)-bit; else sum = {0, ACC[C_NUM_BITS-1:0]}.
    - Then {ACC,Q} <= {sum,Q} shifted right by 1; the sum carry enters the ACC MSB, and the sum LSB enters the Q MSB.
    - CNT <= CNT+1.
    - When CNT = C_NUM_BITS-1 (last iteration): P <= final {ACC[C_NUM_BITS-1:0], Q} in the same edge, then go DONE.
  - DONE: DONE=1 for exactly one cycle; next enabled edge goes IDLE.
- Latency: START accepted at edge k.
  - BUSY high from edge k through edge k+C_NUM_BITS.
  - P updated and DONE high after edge k+C_NUM_BITS.
  - DONE low after edge k+C_NUM_BITS+1.
  - Earliest next START acceptance: edge k+C_NUM_BITS+2 (IDLE). For C_NUM_BITS=4, DONE appears after edge k+4.
- Arithmetic: unsigned only.
  - P = A*B exactly; max 15*15 = 225 = 0xE1 fits 8 bits.
  - The carry bit must never be dropped.
- START while RUN or DONE: ignored; operands not re-captured; in-flight result unaffected.
- A/B changes after acceptance: no effect (captured).
- E low in any state: state, CNT, ACC, Q, P, BUSY, DONE all frozen. A DONE pulse stretches for as many cycles as E stays low. Operation resumes exactly where it stopped when E returns high.
- Reset mid-operation: immediate abort.
  - All registers return to their reset values, including P=0.
  - No DONE is produced for the aborted operation.
- P changes only at the completion edge or at reset; it is stable during RUN and across IDLE.
- DONE and BUSY are never high simultaneously.

Test Plan:
- Reset, then A=7, B=6, START one cycle, E=1 -> BUSY high 4 cycles, then DONE high 1 cycle with P=0x2A (42), then IDLE, P holds 0x2A.
- A=15, B=15 -> P=0xE1; then A=0, B=9 -> P=0x00; then A=1, B=9 -> P=0x09. Each DONE exactly 4 edges after START acceptance.
- Start A=5, B=3; drop E low for 3 cycles after iteration 2 -> state/BUSY frozen, no DONE during gap. DONE arrives 2 enabled edges after E returns, P=0x0F.
- Start A=9, B=9; assert START again with A=2, B=2 during RUN -> second START ignored; P=0x51 (81); DONE once.
- Start A=12, B=11; pulse RN low asynchronously mid-cycle during iteration 3 -> P=0, BUSY=0, DONE=0 immediately, no DONE pulse. After release, A=3, B=4 -> P=0x0C.
- Exhaustive sweep of all 256 A/B pairs, back-to-back at the earliest START acceptance edge -> every P equals A*B, DONE count = 256.

Source files
------------

// File: rtl/multiplier_4bit.sv
// multiplier_4bit: sequential shift-and-add unsigned multiplier with clock enable
module multiplier_4bit #(
  parameter int C_NUM_BITS = 4
) (
  input  logic                    CK,
  input  logic                    RN,
  input  logic                    E,
  input  logic                    START,
  input  logic [C_NUM_BITS-1:0]   A,
  input  logic [C_NUM_BITS-1:0]   B,
  output logic [2*C_NUM_BITS-1:0] P,
  output logic                    BUSY,
  output logic                    DONE
);
  localparam int N  = C_NUM_BITS;
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t        state;
  logic [N:0]    acc;
  logic [N:0]    sum;
  logic [N-1:0]  m;
  logic [N-1:0]  q;
  logic [CW-1:0] cnt;
  // acc[N] is always zero between iterations, so adding the full acc equals adding its low bits
  assign sum = acc + (q[0] ? {1'b0, m} : '0);
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
      P     <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else if (E) begin
      case (state)
        IDLE: if (START) begin
          m     <= A;
          q     <= B;
          acc   <= '0;
          cnt   <= '0;
          BUSY  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          acc <= {1'b0, sum[N:1]};
          q   <= {sum[0], q[N-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            P     <= {sum, q[N-1:1]};
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        default: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multiplier_4bit.sv
// tb_multiplier_4bit: directed table plus corner-case sequences for multiplier_4bit
module tb_multiplier_4bit;
  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       E = 1'b1;
  logic       START = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic [7:0] P;
  logic       BUSY;
  logic       DONE;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  multiplier_4bit #(.C_NUM_BITS(4)) dut (
    .CK(CK), .RN(RN), .E(E), .START(START), .A(A), .B(B),
    .P(P), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CK = ~CK;
  always @(posedge DONE) done_cnt++;

  always @(negedge CK) begin
    checks++;
    if (BUSY && DONE) begin
      errors++;
      $display("FAIL busy_done_overlap: BUSY=%b DONE=%b required not both high", BUSY, DONE);
    end
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // called at a negedge; leaves the DUT in IDLE at a negedge, ready for the earliest next START
  task automatic do_mul(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                        input string name);
    int n;
    A = a; B = b; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    chk({name, "_busy"}, 32'(BUSY), 32'd1);
    n = 0;
    while (!DONE && n < 12) begin
      @(negedge CK);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd4);
    chk({name, "_p"}, 32'(P), 32'(exp));
    @(negedge CK);
    chk({name, "_done_low"}, 32'(DONE), 32'd0);
    chk({name, "_p_hold"}, 32'(P), 32'(exp));
  endtask

  initial begin
    vec_t vt[4];
    int d0;
    vt[0] = '{4'd7, 4'd6, 8'h2A};
    vt[1] = '{4'd15, 4'd15, 8'hE1};
    vt[2] = '{4'd0, 4'd9, 8'h00};
    vt[3] = '{4'd1, 4'd9, 8'h09};
    #12;
    chk("reset_p", 32'(P), 32'd0);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    RN = 1'b1;
    @(negedge CK);
    for (int i = 0; i < 4; i++) do_mul(vt[i].a, vt[i].b, vt[i].exp, $sformatf("vec%0d", i));

    A = 4'd5; B = 4'd3; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    @(negedge CK);
    @(negedge CK);
    E = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      chk("gate_busy", 32'(BUSY), 32'd1);
      chk("gate_done", 32'(DONE), 32'd0);
    end
    E = 1'b1;
    @(negedge CK);
    chk("gate_resume1", 32'(DONE), 32'd0);
    @(negedge CK);
    chk("gate_resume2", 32'(DONE), 32'd1);
    chk("gate_p", 32'(P), 32'h0F);
    E = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CK);
      chk("stretch_done", 32'(DONE), 32'd1);
    end
    E = 1'b1;
    @(negedge CK);
    chk("stretch_end", 32'(DONE), 32'd0);

    d0 = done_cnt;
    A = 4'd9; B = 4'd9; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    @(negedge CK);
    A = 4'd2; B = 4'd2; START = 1'b1;
    @(negedge CK);
    @(negedge CK);
    START = 1'b0;
    @(negedge CK);
    chk("restart_done", 32'(DONE), 32'd1);
    chk("restart_p", 32'(P), 32'h51);
    @(negedge CK);
    @(negedge CK);
    chk("restart_done_count", 32'(done_cnt - d0), 32'd1);

    A = 4'd12; B = 4'd11; START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    @(negedge CK);
    @(negedge CK);
    #2 RN = 1'b0;
    #1;
    chk("abort_p", 32'(P), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    d0 = done_cnt;
    #1 RN = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge CK);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    do_mul(4'd3, 4'd4, 8'h0C, "after_abort");

    d0 = done_cnt;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_mul(4'(a), 4'(b), 8'(a * b), $sformatf("sweep_%0d_%0d", a, b));
    chk("sweep_done_count", 32'(done_cnt - d0), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
